multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore FSM control unit for the multicycle RV32I core. Sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives the datapath mux selects, the write enables and `imm_src` for the immediate extender.
- Sits beside the datapath. Reads opcode/funct fields from the instruction register and `zero` from the ALU.

Parameters:
- MEM_STALL, 1, 1: FETCH/MEMREAD/MEMWRITE wait for `mem_ready`; 0: `mem_ready` is ignored and treated as 1.

Ports:
- clk  input  1  core clock, rising edge
- rstn  input  1  synchronous active-low reset
- opcode  input  7  instr[6:0] from instruction register
- funct3  input  3  instr[14:12]
- zero  input  1  ALU result == 0
- mem_ready  input  1  memory access completes this cycle
- pc_write  output  1  PC register enable
- adr_src  output  1  memory address: 0=PC, 1=ALU result register
- mem_write  output  1  data memory write enable
- ir_write  output  1  instruction/old-PC register enable
- reg_write  output  1  register file write enable
- result_src  output  2  result mux: 00=ALU out reg, 01=read data, 10=ALU result
- alu_src_a  output  2  00=PC, 01=old PC, 10=rs1
- alu_src_b  output  2  00=rs2, 01=imm_ext, 10=constant 4
- alu_op  output  2  00=add, 01=sub/compare, 10=funct-decoded
- imm_src  output  2  0=I, 1=S, 2=B, 3=J
- illegal_instr  output  1  unsupported opcode trapped

Behaviour:
- Outputs decode combinationally from the state register only (Moore). Exceptions: `pc_write` in BRANCH, and the `mem_ready` gating described below.
- Unlisted outputs in a state are 0.
- imm_src is combinational from opcode, valid in every state:
  - 0000011 and 0010011 → 0
  - 0100011 → 1
  - 1100011 → 2
  - 1101111 → 3
  - anything else → 0
- Reset:
  - rstn==0 at a clock edge → state = FETCH.
  - While rstn==0, pc_write, ir_write, mem_write and reg_write are forced to 0. Other outputs show FETCH values.
  - illegal_instr = 0.
  - A reset mid-instruction abandons it: no write enable asserts after the reset edge until the next FETCH completes.
- FETCH:
  - Outputs: adr_src=0, a=00, b=10, alu_op=00, result_src=10.
  - When mem_ready: ir_write=1, pc_write=1, then → DECODE. Otherwise hold, with ir_write and pc_write at 0.
- DECODE: a=01, b=01, alu_op=00 (branch target). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - other → FETCH (NOP), or TRAP if the optional feature is compiled in
- MEMADR: a=10, b=01, alu_op=00. Next → MEMREAD if opcode==0000011, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. When mem_ready → MEMWB, else hold.
- MEMWB: result_src=01, reg_write=1, then → FETCH.
- MEMWRITE:
  - adr_src=1, result_src=00.
  - mem_write=1 held throughout the access.
  - When mem_ready → FETCH, else hold.
- EXECR: a=10, b=00, alu_op=10, then → ALUWB.
- EXECI: a=10, b=01, alu_op=10, then → ALUWB.
- ALUWB: result_src=00, reg_write=1, then → FETCH.
- BRANCH:
  - a=10, b=00, alu_op=01, result_src=00.
  - pc_write=zero when funct3==000, pc_write=!zero when funct3==001, 0 for other funct3.
  - Next → FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1, then → ALUWB (writes PC+4 to rd).
- Instruction latency from FETCH entry, with mem_ready held at 1:
  - lw 5 cycles
  - sw 4 cycles
  - R/I 4 cycles
  - branch 3 cycles
  - jal 4 cycles
  - unknown opcode 2 cycles
- Each stalled cycle with mem_ready==0 adds 1 cycle.
- With MEM_STALL=0, mem_ready is treated as 1 regardless of its value.
- At most one of reg_write and mem_write is asserted in any cycle.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE → TRAP.
  - TRAP asserts illegal_instr=1 and holds all write enables at 0.
  - TRAP is left only by reset.
- Undefined:
  - No TRAP state; an unknown opcode returns to FETCH as a NOP.
  - illegal_instr is tied to 0.

Test Plan:
- Reset, then rstn=1, mem_ready=1, opcode=0000011: state path FETCH,DECODE,MEMADR,MEMREAD,MEMWB. reg_write=1 with result_src=01 only in the 5th cycle. imm_src=0 throughout.
- opcode=0100011, mem_ready low for 2 cycles in MEMWRITE: mem_write=1 for exactly 3 cycles, reg_write never 1, then FETCH. imm_src=1.
- opcode=1100011: funct3=000/zero=1 → pc_write=1 in the BRANCH cycle; funct3=001/zero=1 → pc_write=0; funct3=100 → pc_write=0. imm_src=2.
- opcode=1101111: pc_write=1 in the JAL cycle, ALUWB next with reg_write=1, result_src=00. imm_src=3.
- mem_ready=0 for 3 cycles in FETCH: ir_write=0 and pc_write=0 while stalled, a single ir_write/pc_write pulse on release. Repeat with MEM_STALL=0: no stall.
- opcode=1111111: without the macro, returns to FETCH after 2 cycles with no writes. With MULTICYCLE_CONTROL_TRAP_EN, illegal_instr=1 persists; rstn=0 for 1 cycle clears it to FETCH.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle: instruction fields and status in, mux selects and write enables out.
// master = control unit, slave = datapath side.
interface multicycle_control_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       illegal_instr;

    modport master (
        input  opcode, funct3, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal_instr
    );

    modport slave (
        output opcode, funct3, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal_instr
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RV32I core; MULTICYCLE_CONTROL_TRAP_EN adds a sticky TRAP state for unknown opcodes.
// Latency: lw 5, sw/R/I/jal 4, branch 3, unknown 2 cycles from FETCH entry; selects come from a registered decode of the state.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold while mem_ready is low (ignored when MEM_STALL=0).
module multicycle_control #(
    parameter bit MEM_STALL = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    multicycle_control_if.master ctl
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL
`ifdef MULTICYCLE_CONTROL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    // Per-state Moore values; pc/ir enables that depend on live inputs are carried as qualifiers.
    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_always;
        logic       fetch;
        logic       branch;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
        logic       illegal;
`endif
    } ctl_t;

    function automatic ctl_t ctl_of(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.fetch      = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_always = 1'b1;
            end
`ifdef MULTICYCLE_CONTROL_TRAP_EN
            S_TRAP: begin
                c.illegal = 1'b1;
            end
`endif
            default: ;
        endcase
        return c;
    endfunction

    state_t state;
    state_t state_nxt;
    ctl_t   mo;
    ctl_t   sel;
    logic   ready;
    logic   br_take;

    assign ready = MEM_STALL ? ctl.mem_ready : 1'b1;

    always_comb begin
        br_take = 1'b0;
        case (ctl.funct3)
            3'b000:  br_take = ctl.zero;
            3'b001:  br_take = ~ctl.zero;
            default: br_take = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    state_nxt = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (ctl.opcode)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE:          state_nxt = S_EXECR;
                    OP_ITYPE:          state_nxt = S_EXECI;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    OP_JAL:            state_nxt = S_JAL;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
                    default:           state_nxt = S_TRAP;
`else
                    default:           state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_nxt = (ctl.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_nxt = ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: state_nxt = ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_nxt = S_ALUWB;
            S_EXECI:    state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
            S_JAL:      state_nxt = S_ALUWB;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
            S_TRAP:     state_nxt = S_TRAP;
`endif
            default:    state_nxt = S_FETCH;
        endcase
    end

    // The decode of the next state is registered with it, so selects leave a flop.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_FETCH;
            mo    <= ctl_of(S_FETCH);
        end else begin
            state <= state_nxt;
            mo    <= ctl_of(state_nxt);
        end
    end

    // While reset is held, show FETCH selects and keep every write enable off.
    always_comb sel = rstn ? mo : ctl_of(S_FETCH);

    assign ctl.adr_src    = sel.adr_src;
    assign ctl.result_src = sel.result_src;
    assign ctl.alu_src_a  = sel.alu_src_a;
    assign ctl.alu_src_b  = sel.alu_src_b;
    assign ctl.alu_op     = sel.alu_op;
    assign ctl.mem_write  = rstn & sel.mem_write;
    assign ctl.reg_write  = rstn & sel.reg_write;
    assign ctl.ir_write   = rstn & sel.fetch & ready;
    assign ctl.pc_write   = rstn & (sel.pc_always | (sel.fetch & ready) | (sel.branch & br_take));

`ifdef MULTICYCLE_CONTROL_TRAP_EN
    assign ctl.illegal_instr = sel.illegal;
`else
    assign ctl.illegal_instr = 1'b0;
`endif

    always_comb begin
        ctl.imm_src = 2'd0;
        case (ctl.opcode)
            OP_LOAD, OP_ITYPE: ctl.imm_src = 2'd0;
            OP_STORE:          ctl.imm_src = 2'd1;
            OP_BRANCH:         ctl.imm_src = 2'd2;
            OP_JAL:            ctl.imm_src = 2'd3;
            default:           ctl.imm_src = 2'd0;
        endcase
    end

endmodule
